// File: rtl/i2c_pwm_multi.sv
// I2C-programmable multi-channel PWM: a byte-wide register file (duty shadows + enable mask)
// behind a 7-bit I2C slave, feeding one shared prescaler/period counter and per-channel comparators.
module i2c_pwm_multi #(
   parameter logic [6:0] ADDR     = 7'h55,
   parameter int         CHANNELS = 4,
   parameter int         PRESCALE = 31
) (
   input  logic                CLK_IN,
   input  logic                RST_N,
   input  logic                SCK,
   input  logic                SDA_IN,
   output logic                SDA_OE,
   output logic [CHANNELS-1:0] PWM_OUT
);
   localparam int PW  = $clog2(CHANNELS + 1);
   localparam int PSW = (PRESCALE > 0) ? $clog2(PRESCALE + 1) : 1;
   localparam int MW  = (CHANNELS < 8) ? CHANNELS : 8;
   localparam logic [7:0]     MAX_PTR  = 8'(CHANNELS);
   localparam logic [PW-1:0]  MASK_PTR = PW'(CHANNELS);
   localparam logic [PSW-1:0] PRE_LAST = PSW'(PRESCALE);

   typedef enum logic [3:0] {
      ST_IDLE, ST_ADDR, ST_ACK_A, ST_PTR, ST_ACK_P, ST_WDATA, ST_ACK_W, ST_RDATA, ST_MACK
   } state_t;

   logic r_sck_meta, r_sck_sync, r_sck_prev;
   logic r_sda_meta, r_sda_sync, r_sda_prev;
   state_t        r_state;
   logic [7:0]    r_shift;
   logic [3:0]    r_cnt;
   logic [PW-1:0] r_ptr;
   logic          r_rw;
   logic          r_nack;
   logic          r_oe;

   logic [PSW-1:0]      r_pre;
   logic [7:0]          r_count;
   logic [7:0]          r_shadow [CHANNELS];
   logic [7:0]          r_active [CHANNELS];
   logic [MW-1:0]       r_mask;
   logic [CHANNELS-1:0] r_pwm;

   logic w_sck_rise, w_sck_fall, w_start, w_stop;
   logic w_wr_en, w_tick, w_wrap;
   logic [PW-1:0]       w_ptr_inc;
   logic [7:0]          w_rd_byte;
   logic [7:0]          w_count_next;
   logic [7:0]          w_shadow_next [CHANNELS];
   logic [7:0]          w_active_next [CHANNELS];
   logic [MW-1:0]       w_mask_next;
   logic [CHANNELS-1:0] w_pwm_next;

   // Synchronisers reset to the idle-bus level so releasing reset never fakes an edge.
   always_ff @(posedge CLK_IN or negedge RST_N) begin
      if (!RST_N) begin
         r_sck_meta <= 1'b1; r_sck_sync <= 1'b1; r_sck_prev <= 1'b1;
         r_sda_meta <= 1'b1; r_sda_sync <= 1'b1; r_sda_prev <= 1'b1;
      end else begin
         r_sck_meta <= SCK;    r_sck_sync <= r_sck_meta; r_sck_prev <= r_sck_sync;
         r_sda_meta <= SDA_IN; r_sda_sync <= r_sda_meta; r_sda_prev <= r_sda_sync;
      end
   end

   assign w_sck_rise = r_sck_sync & ~r_sck_prev;
   assign w_sck_fall = ~r_sck_sync & r_sck_prev;
   assign w_start    = r_sck_sync & r_sck_prev & r_sda_prev & ~r_sda_sync;
   assign w_stop     = r_sck_sync & r_sck_prev & ~r_sda_prev & r_sda_sync;
   assign w_wr_en    = (r_state == ST_WDATA) && w_sck_fall && (r_cnt == 4'd8);
   assign w_ptr_inc  = (r_ptr == MASK_PTR) ? '0 : r_ptr + 1'b1;

   always_comb begin
      w_rd_byte = 8'h00;
      for (int n = 0; n < CHANNELS; n++)
         if (r_ptr == PW'(n)) w_rd_byte = r_shadow[n];
      if (r_ptr == MASK_PTR) w_rd_byte = 8'(r_mask);
   end

   always_ff @(posedge CLK_IN or negedge RST_N) begin
      if (!RST_N) begin
         r_state <= ST_IDLE;
         r_shift <= '0;
         r_cnt   <= '0;
         r_ptr   <= '0;
         r_rw    <= 1'b0;
         r_nack  <= 1'b1;
         r_oe    <= 1'b0;
      end else if (w_stop) begin
         r_state <= ST_IDLE;
         r_oe    <= 1'b0;
      end else if (w_start) begin
         r_state <= ST_ADDR;
         r_cnt   <= '0;
         r_oe    <= 1'b0;
      end else begin
         case (r_state)
            ST_ADDR, ST_PTR, ST_WDATA: begin
               if (w_sck_rise) begin
                  r_shift <= {r_shift[6:0], r_sda_sync};
                  r_cnt   <= r_cnt + 4'd1;
               end else if (w_sck_fall && r_cnt == 4'd8) begin
                  r_cnt <= '0;
                  if (r_state == ST_ADDR) begin
                     if (r_shift[7:1] == ADDR) begin
                        r_state <= ST_ACK_A;
                        r_rw    <= r_shift[0];
                        r_oe    <= 1'b1;
                     end else begin
                        r_state <= ST_IDLE;
                     end
                  end else if (r_state == ST_PTR) begin
                     if (r_shift <= MAX_PTR) begin
                        r_ptr   <= PW'(r_shift);
                        r_state <= ST_ACK_P;
                        r_oe    <= 1'b1;
                     end else begin
                        r_state <= ST_IDLE;
                     end
                  end else begin
                     r_ptr   <= w_ptr_inc;
                     r_state <= ST_ACK_W;
                     r_oe    <= 1'b1;
                  end
               end
            end
            ST_ACK_A: begin
               if (w_sck_fall) begin
                  if (r_rw) begin
                     r_state <= ST_RDATA;
                     r_shift <= {w_rd_byte[6:0], 1'b0};
                     r_oe    <= ~w_rd_byte[7];
                     r_cnt   <= 4'd1;
                  end else begin
                     r_state <= ST_PTR;
                     r_oe    <= 1'b0;
                     r_cnt   <= '0;
                  end
               end
            end
            ST_ACK_P, ST_ACK_W: begin
               if (w_sck_fall) begin
                  r_state <= ST_WDATA;
                  r_oe    <= 1'b0;
                  r_cnt   <= '0;
               end
            end
            ST_RDATA: begin
               if (w_sck_fall) begin
                  if (r_cnt == 4'd8) begin
                     r_state <= ST_MACK;
                     r_oe    <= 1'b0;
                     r_ptr   <= w_ptr_inc;
                  end else begin
                     r_oe    <= ~r_shift[7];
                     r_shift <= {r_shift[6:0], 1'b0};
                     r_cnt   <= r_cnt + 4'd1;
                  end
               end
            end
            ST_MACK: begin
               if (w_sck_rise) begin
                  r_nack <= r_sda_sync;
               end else if (w_sck_fall) begin
                  if (!r_nack) begin
                     r_state <= ST_RDATA;
                     r_shift <= {w_rd_byte[6:0], 1'b0};
                     r_oe    <= ~w_rd_byte[7];
                     r_cnt   <= 4'd1;
                  end else begin
                     r_state <= ST_IDLE;
                  end
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign w_tick       = (r_pre == PRE_LAST);
   assign w_wrap       = w_tick && (r_count == 8'hFF);
   assign w_count_next = w_tick ? r_count + 8'd1 : r_count;
   assign w_mask_next  = (w_wr_en && r_ptr == MASK_PTR) ? r_shift[MW-1:0] : r_mask;

   // A write landing on the wrap edge is forwarded so it commits in that same wrap.
   // The mask is one byte wide: channels 8..15 share enables with channels 0..7.
   generate
      for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
         assign w_shadow_next[gi] = (w_wr_en && r_ptr == PW'(gi)) ? r_shift : r_shadow[gi];
         assign w_active_next[gi] = w_wrap ? w_shadow_next[gi] : r_active[gi];
         assign w_pwm_next[gi]    = w_mask_next[gi % MW] & (w_count_next < w_active_next[gi]);
      end
   endgenerate

   always_ff @(posedge CLK_IN or negedge RST_N) begin
      if (!RST_N) begin
         r_pre   <= '0;
         r_count <= '0;
         r_mask  <= '0;
         r_pwm   <= '0;
         for (int n = 0; n < CHANNELS; n++) begin
            r_shadow[n] <= '0;
            r_active[n] <= '0;
         end
      end else begin
         r_pre    <= w_tick ? '0 : r_pre + 1'b1;
         r_count  <= w_count_next;
         r_mask   <= w_mask_next;
         r_pwm    <= w_pwm_next;
         r_shadow <= w_shadow_next;
         r_active <= w_active_next;
      end
   end

   assign SDA_OE  = r_oe;
   assign PWM_OUT = r_pwm;

endmodule

// File: tb/tb_i2c_pwm_multi.sv
// Bench for i2c_pwm_multi: bit-banged I2C master, register/PWM reference model and a
// scoreboard whose monitor pairs every observed response with its queued expectation.
module tb_i2c_pwm_multi;
   localparam int C      = 4;
   localparam int P      = 1;
   localparam int Q      = 8;
   localparam int PERIOD = 256 * (P + 1);

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic scl = 1'b1;
   logic m_sda = 1'b1;
   logic sda_oe;
   logic [C-1:0] pwm;
   wire  sda_bus = m_sda & ~sda_oe;

   always #5 clk = ~clk;

   i2c_pwm_multi #(.ADDR(7'h55), .CHANNELS(C), .PRESCALE(P)) dut (
      .CLK_IN (clk),
      .RST_N  (rst_n),
      .SCK    (scl),
      .SDA_IN (sda_bus),
      .SDA_OE (sda_oe),
      .PWM_OUT(pwm)
   );

   typedef struct { string name; int val; } item_t;
   item_t q_exp[$];
   item_t q_obs[$];
   int checks = 0;
   int errors = 0;

   int model_duty [C];
   int model_mask = 0;
   int model_ptr  = 0;
   logic [7:0] wdata_q[$];
   int oe_cycles = 0;

   always @(posedge clk) if (sda_oe) oe_cycles++;

   function automatic void push_exp(string n, int v);
      item_t it; it.name = n; it.val = v; q_exp.push_back(it);
   endfunction
   function automatic void push_obs(string n, int v);
      item_t it; it.name = n; it.val = v; q_obs.push_back(it);
   endfunction

   initial begin
      item_t ob, ex;
      forever begin
         wait (q_obs.size() != 0);
         ob = q_obs.pop_front();
         checks++;
         if (q_exp.size() == 0) begin
            errors++;
            $display("FAIL %s: got %0d with no expected value queued", ob.name, ob.val);
         end else begin
            ex = q_exp.pop_front();
            if (ex.val != ob.val) begin
               errors++;
               $display("FAIL %s: got %0d expected %0d", ob.name, ob.val, ex.val);
            end else begin
               $display("ok   %s = %0d", ob.name, ob.val);
            end
         end
      end
   end

   function automatic int model_reg(int i);
      return (i < C) ? model_duty[i] : model_mask;
   endfunction
   function automatic int ptr_next(int i);
      return (i == C) ? 0 : i + 1;
   endfunction
   function automatic void model_write(int d);
      if (model_ptr < C) model_duty[model_ptr] = d;
      else model_mask = d & ((1 << C) - 1);
      model_ptr = ptr_next(model_ptr);
   endfunction
   function automatic void model_reset();
      for (int i = 0; i < C; i++) model_duty[i] = 0;
      model_mask = 0;
      model_ptr  = 0;
   endfunction

   task automatic wq();
      repeat (Q) @(posedge clk);
   endtask
   task automatic i2c_start();
      m_sda = 1'b1; wq(); scl = 1'b1; wq(); m_sda = 1'b0; wq(); scl = 1'b0; wq();
   endtask
   task automatic i2c_stop();
      m_sda = 1'b0; wq(); scl = 1'b1; wq(); m_sda = 1'b1; wq();
   endtask
   task automatic bit_out(input logic b);
      m_sda = b; wq(); scl = 1'b1; wq(); wq(); scl = 1'b0; wq();
   endtask
   task automatic bit_in(output logic b);
      m_sda = 1'b1; wq(); scl = 1'b1; wq(); #1 b = sda_bus; wq(); scl = 1'b0; wq();
   endtask
   task automatic byte_out(input logic [7:0] d, output logic ack);
      logic a;
      for (int i = 7; i >= 0; i--) bit_out(d[i]);
      bit_in(a);
      ack = ~a;
   endtask
   task automatic byte_in(output logic [7:0] d, input logic ack);
      logic b;
      for (int i = 7; i >= 0; i--) begin bit_in(b); d[i] = b; end
      bit_out(~ack);
   endtask

   // Write transaction: address byte, pointer byte, then every byte queued in wdata_q.
   task automatic wr_txn(input logic [7:0] addr_byte, input int ptr);
      logic ack;
      bit alive;
      alive = (addr_byte[7:1] == 7'h55) && !addr_byte[0];
      i2c_start();
      push_exp("addr_ack", int'(alive));
      byte_out(addr_byte, ack);
      push_obs("addr_ack", int'(ack));
      if (alive && ptr <= C) model_ptr = ptr; else alive = 0;
      push_exp("ptr_ack", int'(alive));
      byte_out(8'(ptr), ack);
      push_obs("ptr_ack", int'(ack));
      while (wdata_q.size() != 0) begin
         logic [7:0] d;
         d = wdata_q.pop_front();
         push_exp("data_ack", int'(alive));
         byte_out(d, ack);
         push_obs("data_ack", int'(ack));
         if (alive) model_write(int'(d));
      end
      i2c_stop();
   endtask

   // Set pointer, repeated START, read n bytes (ACK all but the last).
   task automatic rd_txn(input int ptr, input int n);
      logic ack;
      logic [7:0] d;
      i2c_start();
      push_exp("addr_ack", 1);
      byte_out(8'hAA, ack);
      push_obs("addr_ack", int'(ack));
      push_exp("ptr_ack", 1);
      byte_out(8'(ptr), ack);
      push_obs("ptr_ack", int'(ack));
      model_ptr = ptr;
      i2c_start();
      push_exp("raddr_ack", 1);
      byte_out(8'hAB, ack);
      push_obs("raddr_ack", int'(ack));
      for (int k = 0; k < n; k++) begin
         push_exp($sformatf("rd_reg%0d", model_ptr), model_reg(model_ptr));
         byte_in(d, k < n - 1);
         push_obs($sformatf("rd_reg%0d", model_ptr), int'(d));
         model_ptr = ptr_next(model_ptr);
      end
      i2c_stop();
   endtask

   // High time over one full period is duty*(P+1) cycles once the duty has committed.
   task automatic pwm_measure();
      int hi [C];
      repeat (2 * PERIOD) @(posedge clk);
      for (int c = 0; c < C; c++) begin
         hi[c] = 0;
         push_exp($sformatf("pwm_hi%0d", c), ((model_mask >> c) & 1) ? model_duty[c] * (P + 1) : 0);
      end
      repeat (PERIOD) begin
         @(negedge clk);
         for (int c = 0; c < C; c++) if (pwm[c]) hi[c]++;
      end
      for (int c = 0; c < C; c++) push_obs($sformatf("pwm_hi%0d", c), hi[c]);
   endtask

   initial begin
      int o0;
      logic [7:0] d;
      model_reset();
      repeat (4) @(posedge clk);
      #1;
      push_exp("rst_oe", 0);  push_obs("rst_oe", int'(sda_oe));
      push_exp("rst_pwm", 0); push_obs("rst_pwm", int'(pwm));
      @(negedge clk) rst_n = 1'b1;
      repeat (10) @(posedge clk);

      wdata_q = '{8'h40, 8'h80};
      wr_txn(8'hAA, 0);
      wdata_q = '{8'h03};
      wr_txn(8'hAA, C);
      pwm_measure();

      o0 = oe_cycles;
      wdata_q = '{8'h11, 8'h22};
      wr_txn(8'hA8, 0);
      push_exp("mismatch_oe_cycles", 0);
      push_obs("mismatch_oe_cycles", oe_cycles - o0);
      rd_txn(0, C + 1);

      wdata_q = '{8'h77};
      wr_txn(8'hAA, C + 1);
      for (int i = 0; i < 4; i++) wdata_q.push_back(8'($urandom));
      wr_txn(8'hAA, 3);
      rd_txn(3, 4);
      rd_txn(0, 3);

      for (int it = 0; it < 3; it++) begin
         int n;
         n = $urandom_range(1, 5);
         for (int i = 0; i < n; i++) wdata_q.push_back(8'($urandom));
         wr_txn(8'hAA, $urandom_range(0, C));
         rd_txn($urandom_range(0, C), $urandom_range(1, 5));
      end
      for (int i = 0; i < C; i++) wdata_q.push_back(8'($urandom_range(1, 255)));
      wdata_q.push_back(8'($urandom) | 8'h05);
      wr_txn(8'hAA, 0);
      pwm_measure();

      // Reset in the middle of a data byte, then a clean transaction.
      i2c_start();
      byte_out(8'hAA, d[0]);
      byte_out(8'h00, d[0]);
      for (int i = 0; i < 4; i++) bit_out(1'b1);
      @(negedge clk) rst_n = 1'b0;
      #1;
      model_reset();
      push_exp("midrst_oe", 0);  push_obs("midrst_oe", int'(sda_oe));
      push_exp("midrst_pwm", 0); push_obs("midrst_pwm", int'(pwm));
      scl = 1'b1; wq(); m_sda = 1'b1; wq();
      @(negedge clk) rst_n = 1'b1;
      repeat (10) @(posedge clk);
      rd_txn(0, C + 1);
      wdata_q = '{8'h5A, 8'hC3};
      wr_txn(8'hAA, 1);
      rd_txn(0, C + 1);

      for (int i = 0; i < 200 && q_obs.size() != 0; i++) @(posedge clk);
      if (q_exp.size() != 0 || q_obs.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL scoreboard_drain: %0d expected and %0d observed left, required 0", q_exp.size(), q_obs.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/i2c_pwm_multi.md
I2C_PWM_MULTI -- requirements
Module: i2c_pwm_multi

Interface
REQ-001 SHALL have parameter ADDR, default 7'h55, 7-bit I2C slave address.
REQ-002 SHALL have parameter CHANNELS, default 4, number of PWM channels, legal range 1..16.
REQ-003 SHALL have parameter PRESCALE, default 31, PWM tick divider; tick every PRESCALE+1 CLK_IN cycles.
REQ-004 SHALL have port CLK_IN input 1, the single system clock; all logic on its rising edge.
REQ-005 SHALL have port RST_N input 1, asynchronous active-low reset.
REQ-006 SHALL have port SCK input 1, I2C SCL, asynchronous to CLK_IN.
REQ-007 SHALL have port SDA_IN input 1, I2C SDA pad sense, asynchronous to CLK_IN.
REQ-008 SHALL have port SDA_OE output 1; 1 drives the SDA pad low, 0 releases it (open-drain).
REQ-009 SHALL have port PWM_OUT output CHANNELS; one PWM output per channel.

Function
REQ-010 SHALL synchronise SCK and SDA_IN through 2 flops each; edge and START/STOP detection use the synchronised values only.
REQ-011 SHALL detect START as synchronised SDA falling while SCK high, and STOP as SDA rising while SCK high.
REQ-012 SHALL sample SDA on the synchronised SCK rising edge and change SDA_OE only on the synchronised SCK falling edge.
REQ-013 SHALL implement states IDLE, ADDR, ACK_A, PTR, ACK_P, WDATA, ACK_W, RDATA, MACK.
REQ-014 SHALL move IDLE->ADDR on START; shift 8 bits MSB first; on match of bits[7:1] with ADDR go to ACK_A, else to IDLE without ACK.
REQ-015 SHALL drive SDA_OE=1 for one SCK low-high-low ACK slot in ACK_A, ACK_P and ACK_W.
REQ-016 SHALL, after ACK_A, go to PTR on R/W=0 and to RDATA on R/W=1.
REQ-017 SHALL load the received PTR byte into the register pointer, ACK it if pointer <= CHANNELS, otherwise NACK and return to IDLE.
REQ-018 SHALL map registers: 0..CHANNELS-1 = duty shadow of channel n; CHANNELS = enable mask, bit n enables channel n; unused mask bits read 0.
REQ-019 SHALL, in WDATA, write the byte to the pointed register at ACK_W, increment the pointer, and wrap it from CHANNELS to 0.
REQ-020 SHALL, in RDATA, shift out the pointed register MSB first via SDA_OE (bit 0 -> OE=1), then release SDA in MACK.
REQ-021 SHALL, in MACK, increment and wrap the pointer; on master ACK (SDA low) continue RDATA, on NACK go to IDLE.
REQ-022 SHALL treat START in any non-IDLE state as repeated START: release SDA, go to ADDR, keep the pointer.
REQ-023 SHALL treat STOP in any state as return to IDLE with SDA_OE=0 within 1 CLK_IN cycle; pointer kept.
REQ-024 SHALL run one prescaler shared by all channels and one 8-bit period counter per block, counting 0..255 on each tick and wrapping.
REQ-025 SHALL copy each duty shadow into its active duty register only when the period counter wraps 255->0 (glitch-free update).
REQ-026 SHALL drive PWM_OUT[n] = enable[n] AND (counter < active_duty[n]); duty 0 = constantly low, duty 255 = high 255 of 256 ticks.
REQ-027 SHALL apply enable-mask changes immediately (registered, 1 CLK_IN cycle after the ACK_W write).
REQ-028 SHALL give an I2C write and a simultaneous period wrap a defined order: the write completes first and is committed in that same wrap.

Reset
REQ-029 SHALL on RST_N=0 asynchronously set SDA_OE=0, PWM_OUT=0, state IDLE, pointer 0, all duty shadows, active duties and enable mask 0, prescaler and counter 0.
REQ-030 SHALL on reset mid-transfer abandon the transfer and ignore the bus until the next START after RST_N=1.

Verification
REQ-031 SHALL be checked: write addr 0xAA, ptr 0x00, data 0x40, 0x80 -> ACKs on all bytes, duty0=0x40, duty1=0x80 after next wrap.
REQ-032 SHALL be checked: write ptr 0x04 (enable) data 0x03 -> PWM_OUT[0] high 64 ticks, PWM_OUT[1] high 128 ticks per 256-tick period.
REQ-033 SHALL be checked: address 0xA8 (mismatch) -> SDA_OE stays 0 throughout, no register changes.
REQ-034 SHALL be checked: write ptr 0x05 -> NACK; ptr 0x03 data x4 -> regs 3,4,0,1 written (wrap).
REQ-035 SHALL be checked: write ptr 0x00, repeated START, read 0xAB, 3 bytes ACK,ACK,NACK -> returns duty0, duty1, duty2, then IDLE.
REQ-036 SHALL be checked: RST_N low during WDATA bit 4 -> all outputs 0 immediately; next full write transaction succeeds.
